// File: rtl/trig_event_pkg.sv
// Shared constants for the trigger event generator: trig_out bit positions and FSM states.
package trig_event_pkg;

  localparam int TRIG_RISE     = 0;
  localparam int TRIG_FALL     = 1;
  localparam int TRIG_TICK     = 2;
  localparam int TRIG_WRAP     = 3;
  localparam int TRIG_EXT_BASE = 8;
  localparam int TRIG_ARMED    = 16;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2
  } trig_state_e;

endpackage

// File: rtl/trig_holdoff_ctr.sv
// Loadable down-counter for crossing suppression; done_o flags the last suppressed cycle.
module trig_holdoff_ctr
  import trig_event_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/trig_event_gen.sv
// Trigger event generator for an okTriggerOut endpoint: threshold crossings, wrap, tick, external edges.
// Define TRIG_EXT_EVT_EN to build the external edge detectors (trig_out bits 8..15).
module trig_event_gen
  import trig_event_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXT_N     = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     count_in,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [31:0]          period,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 single_shot,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [EXT_N-1:0]     ext_evt,
  output logic [31:0]          trig_out,
  output logic                 armed,
  output logic [15:0]          evt_count
);

  trig_state_e      state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid_q;
  logic [31:0]      tick_q, tick_d;
  logic [31:0]      trig_q, trig_d;
  logic             armed_q;
  logic [15:0]      evt_q, evt_d;

  logic             rise, fall, wrap, tick_hit;
  logic             ho_load, ho_clear, ho_done;
  logic [EXT_N-1:0] ext_rise;

  assign rise = prev_valid_q && (prev_q <  threshold) && (count_in >= threshold);
  assign fall = prev_valid_q && (prev_q >= threshold) && (count_in <  threshold);
  assign wrap = prev_valid_q && (&prev_q) && (count_in == '0);

  // A shrinking period that lands at or below the current count terminates immediately.
  always_comb begin
    tick_d   = tick_q + 32'd1;
    tick_hit = 1'b0;
    if (period == 32'd0) begin
      tick_d = '0;
    end else if (({1'b0, tick_q} + 33'd1) >= {1'b0, period}) begin
      tick_d   = '0;
      tick_hit = 1'b1;
    end
  end

`ifdef TRIG_EXT_EVT_EN
  logic [EXT_N-1:0] ext_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= '0;
    end else begin
      ext_q <= ext_evt;
    end
  end

  assign ext_rise = ext_evt & ~ext_q;
`else
  logic unused_ext;
  assign unused_ext = ^ext_evt;
  assign ext_rise   = '0;
`endif

  // Disarm has priority over everything, including a coincident arm or crossing.
  always_comb begin
    state_d  = state_q;
    evt_d    = evt_q;
    ho_load  = 1'b0;
    ho_clear = 1'b0;
    trig_d   = '0;
    trig_d[TRIG_TICK] = tick_hit;
    trig_d[TRIG_WRAP] = wrap;
    trig_d[TRIG_EXT_BASE +: EXT_N] = ext_rise;

    if (disarm) begin
      state_d  = ST_DISARMED;
      ho_clear = 1'b1;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            state_d            = ST_ARMED;
            evt_d              = '0;
            trig_d[TRIG_ARMED] = 1'b1;
          end
        end
        ST_ARMED: begin
          if (rise || fall) begin
            trig_d[TRIG_RISE] = rise;
            trig_d[TRIG_FALL] = fall;
            if (evt_q != 16'hFFFF) begin
              evt_d = evt_q + 16'd1;
            end
            if (single_shot) begin
              state_d = ST_DISARMED;
            end else if (holdoff != '0) begin
              state_d = ST_HOLDOFF;
              ho_load = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (ho_done) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  trig_holdoff_ctr #(
    .W(HOLDOFF_W)
  ) u_holdoff (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (ho_load),
    .load_val_i (holdoff),
    .clear_i    (ho_clear),
    .dec_i      (state_q == ST_HOLDOFF),
    .done_o     (ho_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_DISARMED;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      tick_q       <= '0;
      trig_q       <= '0;
      armed_q      <= 1'b0;
      evt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= count_in;
      prev_valid_q <= 1'b1;
      tick_q       <= tick_d;
      trig_q       <= trig_d;
      armed_q      <= (state_d != ST_DISARMED);
      evt_q        <= evt_d;
    end
  end

  assign trig_out  = trig_q;
  assign armed     = armed_q;
  assign evt_count = evt_q;

endmodule

// File: tb/tb_trig_event_gen.sv
// Directed bench for trig_event_gen with a behavioural reference model checked every cycle.
module tb_trig_event_gen;

  logic        clk;
  logic        reset_n;
  logic [31:0] count_in;
  logic [31:0] threshold;
  logic [31:0] period;
  logic [15:0] holdoff;
  logic        single_shot;
  logic        arm;
  logic        disarm;
  logic [7:0]  ext_evt;
  logic [31:0] trig_out;
  logic        armed;
  logic [15:0] evt_count;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  trig_event_gen #(
    .WIDTH(32),
    .EXT_N(8),
    .HOLDOFF_W(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .count_in    (count_in),
    .threshold   (threshold),
    .period      (period),
    .holdoff     (holdoff),
    .single_shot (single_shot),
    .arm         (arm),
    .disarm      (disarm),
    .ext_evt     (ext_evt),
    .trig_out    (trig_out),
    .armed       (armed),
    .evt_count   (evt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: armed flag plus a count of crossings still to be ignored.
  logic [31:0] mPrev;
  bit          mPrevValid;
  logic [63:0] mTick;
  int          mSuppress;
  bit          mArmed;
  int          mEvt;
  logic [7:0]  mExtPrev;
  logic [31:0] expTrig;
  logic        expArmed;
  logic [15:0] expEvt;

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] t;
    bit r, f;
    if (!reset_n) begin
      mPrev = '0; mPrevValid = 0; mTick = '0; mSuppress = 0; mArmed = 0; mEvt = 0;
      mExtPrev = '0; expTrig = '0; expArmed = 1'b0; expEvt = '0;
    end else begin
      t = '0;
      r = mPrevValid && (mPrev < threshold) && (count_in >= threshold);
      f = mPrevValid && (mPrev >= threshold) && (count_in < threshold);
      if (mPrevValid && mPrev == 32'hFFFF_FFFF && count_in == 32'd0) t[3] = 1'b1;
      if (period == 32'd0) mTick = '0;
      else if (mTick + 64'd1 >= {32'd0, period}) begin t[2] = 1'b1; mTick = '0; end
      else mTick = mTick + 64'd1;
`ifdef TRIG_EXT_EVT_EN
      t[15:8] = ext_evt & ~mExtPrev;
`endif
      mExtPrev = ext_evt;
      if (disarm) begin
        mArmed = 0; mSuppress = 0;
      end else if (!mArmed) begin
        if (arm) begin mArmed = 1; mEvt = 0; t[16] = 1'b1; end
      end else if (mSuppress > 0) begin
        mSuppress = mSuppress - 1;
      end else if (r || f) begin
        if (r) t[0] = 1'b1; else t[1] = 1'b1;
        if (mEvt < 65535) mEvt = mEvt + 1;
        if (single_shot) mArmed = 0;
        else mSuppress = int'(holdoff);
      end
      mPrev = count_in;
      mPrevValid = 1;
      expTrig = t;
      expArmed = mArmed;
      expEvt = 16'(mEvt);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("trig_out_vs_model", trig_out, expTrig);
      checkOutput("armed_vs_model", {31'd0, armed}, {31'd0, expArmed});
      checkOutput("evt_count_vs_model", {16'd0, evt_count}, {16'd0, expEvt});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] cnt, input logic a, input logic d);
    count_in = cnt;
    arm = a;
    disarm = d;
    step();
    arm = 1'b0;
    disarm = 1'b0;
  endtask

  logic [31:0] extExp;

  initial begin
    reset_n = 1'b0;
    count_in = '0; threshold = 32'd10; period = '0; holdoff = '0;
    single_shot = 1'b0; arm = 1'b0; disarm = 1'b0; ext_evt = '0;
`ifdef TRIG_EXT_EVT_EN
    extExp = 32'h0000_0800;
`else
    extExp = 32'h0;
`endif
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_trig", trig_out, 32'h0);
    checkOutput("reset_armed", {31'd0, armed}, 32'h0);
    checkOutput("reset_evt", {16'd0, evt_count}, 32'h0);
    reset_n = 1'b1;
    checkEn = 1'b1;
    $display("[TB] reset released");

    // Test 1: arm, ramp 0..20 through threshold 10
    applyStimulus(32'd0, 1'b1, 1'b0);
    checkOutput("t1_arm_pulse", trig_out, 32'h0001_0000);
    checkOutput("t1_model_pin", expTrig, 32'h0001_0000);
    checkOutput("t1_armed", {31'd0, armed}, 32'h1);
    for (int v = 1; v <= 20; v++) begin
      applyStimulus(32'(v), 1'b0, 1'b0);
      checkOutput("t1_ramp", trig_out, (v == 10) ? 32'h1 : 32'h0);
    end
    checkOutput("t1_evt", {16'd0, evt_count}, 32'd1);

    // Test 2: fall while armed, then single-shot
    applyStimulus(32'd9, 1'b0, 1'b0);
    checkOutput("t2_fall", trig_out, 32'h2);
    checkOutput("t2_evt2", {16'd0, evt_count}, 32'd2);
    single_shot = 1'b1;
    applyStimulus(32'd10, 1'b0, 1'b0);
    checkOutput("t2_single_rise", trig_out, 32'h1);
    checkOutput("t2_disarmed", {31'd0, armed}, 32'h0);
    checkOutput("t2_evt3", {16'd0, evt_count}, 32'd3);
    applyStimulus(32'd9, 1'b0, 1'b0);
    checkOutput("t2_quiet_a", trig_out, 32'h0);
    applyStimulus(32'd10, 1'b0, 1'b0);
    checkOutput("t2_quiet_b", trig_out, 32'h0);
    applyStimulus(32'd9, 1'b0, 1'b0);
    checkOutput("t2_quiet_c", trig_out, 32'h0);
    applyStimulus(32'd9, 1'b1, 1'b0);
    checkOutput("t2_rearm", trig_out, 32'h0001_0000);
    checkOutput("t2_evt_clear", {16'd0, evt_count}, 32'd0);

    // Test 3: holdoff 5 with a crossing offered every cycle
    single_shot = 1'b0;
    holdoff = 16'd5;
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 32'd10 : 32'd9, 1'b0, 1'b0);
      checkOutput("t3_holdoff", trig_out, (i % 6 == 0) ? 32'h1 : 32'h0);
    end
    checkOutput("t3_evt", {16'd0, evt_count}, 32'd4);
    checkOutput("t3_armed", {31'd0, armed}, 32'h1);

    // Test 4: periodic tick
    period = 32'd4;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(32'd9, 1'b0, 1'b0);
      checkOutput("t4_p4", trig_out, (k % 4 == 0) ? 32'h4 : 32'h0);
    end
    period = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'd9, 1'b0, 1'b0);
      checkOutput("t4_p0", trig_out, 32'h0);
    end
    period = 32'd4;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(32'd9, 1'b0, 1'b0);
      checkOutput("t4_p4_again", trig_out, 32'h0);
    end
    period = 32'd2;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'd9, 1'b0, 1'b0);
      checkOutput("t4_p2_shrink", trig_out, (k % 2 == 1) ? 32'h4 : 32'h0);
    end
    period = 32'd0;

    // Test 5: wrap while disarmed, external edge
    applyStimulus(32'd9, 1'b0, 1'b1);
    checkOutput("t5_disarm", {31'd0, armed}, 32'h0);
    checkOutput("t5_evt_held", {16'd0, evt_count}, 32'd4);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("t5_no_cross", trig_out, 32'h0);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkOutput("t5_wrap", trig_out, 32'h8);
    checkOutput("t5_model_pin", expTrig, 32'h8);
    ext_evt = 8'h08;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'd0, 1'b0, 1'b0);
      checkOutput("t5_ext", trig_out, (k == 0) ? extExp : 32'h0);
    end
    ext_evt = 8'h00;

    // Test 6: simultaneous arm/disarm, then reset during holdoff
    applyStimulus(32'd0, 1'b1, 1'b1);
    checkOutput("t6_both_trig", trig_out, 32'h0);
    checkOutput("t6_both_armed", {31'd0, armed}, 32'h0);
    applyStimulus(32'd0, 1'b1, 1'b0);
    checkOutput("t6_arm", trig_out, 32'h0001_0000);
    applyStimulus(32'd10, 1'b0, 1'b0);
    checkOutput("t6_rise", trig_out, 32'h1);
    applyStimulus(32'd9, 1'b0, 1'b0);
    checkOutput("t6_in_holdoff", trig_out, 32'h0);
    checkOutput("t6_armed_holdoff", {31'd0, armed}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_trig", trig_out, 32'h0);
    checkOutput("t6_async_armed", {31'd0, armed}, 32'h0);
    checkOutput("t6_async_evt", {16'd0, evt_count}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(32'd9, 1'b0, 1'b0);
    checkOutput("t6_post_reset", trig_out, 32'h0);
    applyStimulus(32'd9, 1'b1, 1'b0);
    checkOutput("t6_post_arm", trig_out, 32'h0001_0000);
    step();

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
